// File: rtl/pipelined_adder_if.sv
// rtl/pipelined_adder_if.sv - operand/result handshake bundle for pipelined_adder; ovf present with ADDER_OVF_EN
interface pipelined_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef ADDER_OVF_EN
  logic             ovf;
`endif

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
`ifdef ADDER_OVF_EN
    , ovf
`endif
  );

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
`ifdef ADDER_OVF_EN
    , ovf
`endif
  );
endinterface

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - pipelined ripple-carry adder, one chunk per stage; ADDER_OVF_EN adds signed overflow
module pipelined_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  pipelined_adder_if.slave bus
);
  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  logic             valid_q [STAGES];
  logic             valid_d [STAGES];
  logic [WIDTH-1:0] opa_q   [STAGES];
  logic [WIDTH-1:0] opa_d   [STAGES];
  logic [WIDTH-1:0] opb_q   [STAGES];
  logic [WIDTH-1:0] opb_d   [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic [WIDTH-1:0] sum_d   [STAGES];
  logic             carry_q [STAGES];
  logic             carry_d [STAGES];

  logic             stg_valid [STAGES];
  logic [WIDTH-1:0] stg_a     [STAGES];
  logic [WIDTH-1:0] stg_b     [STAGES];
  logic [WIDTH-1:0] stg_sum   [STAGES];
  logic             stg_cin   [STAGES];
  logic [CHUNK:0]   chunk_res [STAGES];
  logic             adv;

  assign adv           = !valid_q[LAST] || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = valid_q[LAST];
  assign bus.sum       = sum_q[LAST];
  assign bus.cout      = carry_q[LAST];

  // Stage k sees the registers of stage k-1; stage 0 sees the input port.
  always_comb begin
    stg_valid[0] = bus.in_valid;
    stg_a[0]     = bus.a;
    stg_b[0]     = bus.b;
    stg_cin[0]   = bus.cin;
    stg_sum[0]   = '0;
    for (int s = 1; s < STAGES; s++) begin
      stg_valid[s] = valid_q[s-1];
      stg_a[s]     = opa_q[s-1];
      stg_b[s]     = opb_q[s-1];
      stg_cin[s]   = carry_q[s-1];
      stg_sum[s]   = sum_q[s-1];
    end
    for (int s = 0; s < STAGES; s++) begin
      chunk_res[s] = {1'b0, stg_a[s][s*CHUNK +: CHUNK]}
                   + {1'b0, stg_b[s][s*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, stg_cin[s]};
    end
  end

  // Data registers load only behind a valid operation so bubbles never disturb the visible result.
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      valid_d[s] = valid_q[s];
      opa_d[s]   = opa_q[s];
      opb_d[s]   = opb_q[s];
      sum_d[s]   = sum_q[s];
      carry_d[s] = carry_q[s];
    end
    if (adv) begin
      for (int s = 0; s < STAGES; s++) begin
        valid_d[s] = stg_valid[s];
        if (stg_valid[s]) begin
          opa_d[s]                   = stg_a[s];
          opb_d[s]                   = stg_b[s];
          sum_d[s]                   = stg_sum[s];
          sum_d[s][s*CHUNK +: CHUNK] = chunk_res[s][CHUNK-1:0];
          carry_d[s]                 = chunk_res[s][CHUNK];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        valid_q[s] <= 1'b0;
        opa_q[s]   <= '0;
        opb_q[s]   <= '0;
        sum_q[s]   <= '0;
        carry_q[s] <= 1'b0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        valid_q[s] <= valid_d[s];
        opa_q[s]   <= opa_d[s];
        opb_q[s]   <= opb_d[s];
        sum_q[s]   <= sum_d[s];
        carry_q[s] <= carry_d[s];
      end
    end
  end

`ifdef ADDER_OVF_EN
  logic ovf_q;
  logic ovf_d;
  logic msb_cin;

  // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c.
  always_comb begin
    msb_cin = stg_a[LAST][WIDTH-1] ^ stg_b[LAST][WIDTH-1] ^ chunk_res[LAST][CHUNK-1];
    ovf_d   = ovf_q;
    if (adv && stg_valid[LAST]) begin
      ovf_d = msb_cin ^ chunk_res[LAST][CHUNK];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - directed bench for pipelined_adder; ovf checks compiled with ADDER_OVF_EN
module tb_pipelined_adder;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(8)) bus  ();
  pipelined_adder_if #(.WIDTH(8)) bus1 ();
  pipelined_adder_if #(.WIDTH(8)) bus4 ();
  pipelined_adder_if #(.WIDTH(8)) bus8 ();

  pipelined_adder #(.WIDTH(8), .STAGES(2)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  pipelined_adder #(.WIDTH(8), .STAGES(1)) u_s1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
  pipelined_adder #(.WIDTH(8), .STAGES(4)) u_s4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
  pipelined_adder #(.WIDTH(8), .STAGES(8)) u_s8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  logic       sw_valid [4];
  logic [8:0] sw_res   [4];
  logic       sw_ovf   [4];
  int         sw_lat   [4] = '{2, 1, 4, 8};

  assign sw_valid[0] = bus.out_valid;
  assign sw_valid[1] = bus1.out_valid;
  assign sw_valid[2] = bus4.out_valid;
  assign sw_valid[3] = bus8.out_valid;
  assign sw_res[0]   = {bus.cout, bus.sum};
  assign sw_res[1]   = {bus1.cout, bus1.sum};
  assign sw_res[2]   = {bus4.cout, bus4.sum};
  assign sw_res[3]   = {bus8.cout, bus8.sum};
`ifdef ADDER_OVF_EN
  assign sw_ovf[0] = bus.ovf;
  assign sw_ovf[1] = bus1.ovf;
  assign sw_ovf[2] = bus4.ovf;
  assign sw_ovf[3] = bus8.ovf;
`else
  assign sw_ovf[0] = 1'b0;
  assign sw_ovf[1] = 1'b0;
  assign sw_ovf[2] = 1'b0;
  assign sw_ovf[3] = 1'b0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_all(input logic [7:0] a, input logic [7:0] b, input logic c, input logic v);
    bus.a  = a; bus.b  = b; bus.cin  = c; bus.in_valid  = v; bus.out_ready  = 1'b1;
    bus1.a = a; bus1.b = b; bus1.cin = c; bus1.in_valid = v; bus1.out_ready = 1'b1;
    bus4.a = a; bus4.b = b; bus4.cin = c; bus4.in_valid = v; bus4.out_ready = 1'b1;
    bus8.a = a; bus8.b = b; bus8.cin = c; bus8.in_valid = v; bus8.out_ready = 1'b1;
  endtask

  // Sends one operation into an idle main DUT and waits for its result.
  task automatic run_single(input logic [7:0] a, input logic [7:0] b, input logic c,
                            output logic [8:0] res, output logic ovf_o, output int lat);
    bus.a = a; bus.b = b; bus.cin = c; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 12) begin
      step();
      lat++;
    end
    res = {bus.cout, bus.sum};
`ifdef ADDER_OVF_EN
    ovf_o = bus.ovf;
`else
    ovf_o = 1'b0;
`endif
  endtask

  function automatic logic [16:0] op_vec(input int i);
    logic [11:0] iv;
    logic [7:0]  a;
    logic [7:0]  b;
    iv = i[11:0];
    a  = iv[11:4];
    case (iv[3:1])
      3'd0:    b = 8'h00;
      3'd1:    b = 8'h01;
      3'd2:    b = 8'h7F;
      3'd3:    b = 8'h80;
      3'd4:    b = 8'hFF;
      3'd5:    b = a;
      3'd6:    b = ~a;
      default: b = a ^ 8'h55;
    endcase
    return {a, b, iv[0]};
  endfunction

  task automatic test_reset();
    drive_all(8'h00, 8'h00, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #22;
    checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready_during: got %b want 1", bus.in_ready);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    else passed++;
    checks++;
    if (bus.sum !== 8'h00) $display("FAIL reset_sum: got %h want 00", bus.sum);
    else passed++;
    checks++;
    if (bus.cout !== 1'b0) $display("FAIL reset_cout: got %b want 0", bus.cout);
    else passed++;
    checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    else passed++;
`ifdef ADDER_OVF_EN
    checks++;
    if (bus.ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", bus.ovf);
    else passed++;
`endif
  endtask

  task automatic test_chunk_carry();
    logic [8:0] res;
    logic       ov;
    int         lat;
    run_single(8'h0F, 8'h01, 1'b0, res, ov, lat);
    checks++;
    if (lat !== 2) $display("FAIL chunk_latency: got %0d want 2", lat);
    else passed++;
    checks++;
    if (res !== 9'h010) $display("FAIL chunk_carry: got %h want 010", res);
    else passed++;
  endtask

  task automatic test_wrap_overflow();
    logic [7:0] va [4] = '{8'hFF, 8'h7F, 8'h80, 8'hFF};
    logic [7:0] vb [4] = '{8'h01, 8'h01, 8'h80, 8'hFF};
    logic       vc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [8:0] ve [4] = '{9'h100, 9'h080, 9'h100, 9'h1FF};
    logic       vo [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [8:0] res;
    logic       ov;
    int         lat;
    for (int i = 0; i < 4; i++) begin
      run_single(va[i], vb[i], vc[i], res, ov, lat);
      checks++;
      if (res !== ve[i]) $display("FAIL wrap_sum[%0d]: got %h want %h", i, res, ve[i]);
      else passed++;
`ifdef ADDER_OVF_EN
      checks++;
      if (ov !== vo[i]) $display("FAIL wrap_ovf[%0d]: got %b want %b", i, ov, vo[i]);
      else passed++;
`else
      if (ov !== 1'b0 && vo[i] === 1'b1) $display("note: unexpected ovf state");
`endif
    end
    step();
  endtask

  task automatic test_streaming();
    logic [7:0] va [4] = '{8'h12, 8'hF0, 8'h88, 8'h3C};
    logic [7:0] vb [4] = '{8'h34, 8'h10, 8'h77, 8'h05};
    logic       vc [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [8:0] ve [4] = '{9'h046, 9'h101, 9'h100, 9'h042};
    bus.out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      if (j < 4) begin
        bus.a = va[j]; bus.b = vb[j]; bus.cin = vc[j]; bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      step();
      if (j >= 1 && j <= 4) begin
        checks++;
        if (bus.out_valid !== 1'b1 || {bus.cout, bus.sum} !== ve[j-1])
          $display("FAIL stream[%0d]: got valid=%b %h want valid=1 %h", j-1, bus.out_valid, {bus.cout, bus.sum}, ve[j-1]);
        else passed++;
      end else if (j == 5) begin
        checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL stream_drain: got valid=%b want 0", bus.out_valid);
        else passed++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] va [4] = '{8'h01, 8'h80, 8'h55, 8'hC3};
    logic [7:0] vb [4] = '{8'h02, 8'h80, 8'hAA, 8'h3C};
    logic       vc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [8:0] ve [4] = '{9'h003, 9'h101, 9'h0FF, 9'h100};
    int   sent = 0;
    int   got = 0;
    int   stalls = 0;
    logic in_f;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      bus.in_valid = (sent < 4);
      if (sent < 4) begin
        bus.a = va[sent]; bus.b = vb[sent]; bus.cin = vc[sent];
      end
      bus.out_ready = !(bus.out_valid && got == 0 && stalls < 3);
      #1;
      if (!bus.out_ready) begin
        stalls++;
        checks++;
        if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %b want 0", stalls, bus.in_ready);
        else passed++;
        checks++;
        if (bus.out_valid !== 1'b1 || {bus.cout, bus.sum} !== ve[0])
          $display("FAIL bp_hold[%0d]: got valid=%b %h want valid=1 %h", stalls, bus.out_valid, {bus.cout, bus.sum}, ve[0]);
        else passed++;
      end
      in_f = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if ({bus.cout, bus.sum} !== ve[got]) $display("FAIL bp_result[%0d]: got %h want %h", got, {bus.cout, bus.sum}, ve[got]);
        else passed++;
        got++;
      end
      step();
      if (in_f) sent++;
    end
    checks++;
    if (got !== 4 || stalls !== 3) $display("FAIL bp_count: got results=%0d stalls=%0d want 4 and 3", got, stalls);
    else passed++;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL bp_no_repeat: got valid=%b want 0", bus.out_valid);
    else passed++;
  endtask

  task automatic test_midop_reset();
    bus.out_ready = 1'b0;
    bus.a = 8'h21; bus.b = 8'h43; bus.cin = 1'b0; bus.in_valid = 1'b1;
    step();
    bus.a = 8'h65; bus.b = 8'h87; bus.cin = 1'b1;
    step();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.sum !== 8'h00) $display("FAIL midreset_drop: got valid=%b sum=%h want 0 00", bus.out_valid, bus.sum);
    else passed++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (bus.out_valid !== 1'b0) $display("FAIL midreset_ghost[%0d]: got valid=%b want 0", i, bus.out_valid);
      else passed++;
    end
  endtask

  task automatic test_sweep();
    localparam int N = 4096;
    logic [16:0] v;
    logic [8:0]  e;
    for (int j = 0; j < N + 8; j++) begin
      if (j < N) begin
        v = op_vec(j);
        drive_all(v[16:9], v[8:1], v[0], 1'b1);
      end else begin
        drive_all(8'h00, 8'h00, 1'b0, 1'b0);
      end
      step();
      for (int d = 0; d < 4; d++) begin
        int idx;
        idx = j - sw_lat[d] + 1;
        checks++;
        if (idx >= 0 && idx < N) begin
          v = op_vec(idx);
          e = {1'b0, v[16:9]} + {1'b0, v[8:1]} + {8'h00, v[0]};
          if (sw_valid[d] !== 1'b1 || sw_res[d] !== e)
            $display("FAIL sweep_s%0d[%0d]: got valid=%b %h want valid=1 %h", sw_lat[d], idx, sw_valid[d], sw_res[d], e);
          else passed++;
`ifdef ADDER_OVF_EN
          checks++;
          if (sw_ovf[d] !== ((v[16] == v[8]) && (e[7] != v[16])))
            $display("FAIL sweep_ovf_s%0d[%0d]: got %b want %b", sw_lat[d], idx, sw_ovf[d], (v[16] == v[8]) && (e[7] != v[16]));
          else passed++;
`endif
        end else begin
          if (sw_valid[d] !== 1'b0) $display("FAIL sweep_idle_s%0d[%0d]: got valid=%b want 0", sw_lat[d], j, sw_valid[d]);
          else passed++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_chunk_carry();
    test_wrap_overflow();
    test_streaming();
    test_backpressure();
    test_midop_reset();
    test_sweep();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
